// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the multi-cycle control unit.
//   - 8-bit opcode constants (opcodes wider than 8 bits are compared
//     zero-extended by the FSM before these are used)
//   - ALU function codes driven on alu_op
//   - FSM state enum and decode classes
//   - decode helper functions
package uc_pkg;

  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] OPC_MUL  = 8'h03;
  localparam logic [7:0] OPC_DIV  = 8'h04;
  localparam logic [7:0] OPC_MOD  = 8'h05;
  localparam logic [7:0] OPC_CMP  = 8'h1F;
  localparam logic [7:0] OPC_SHL  = 8'h3C;
  localparam logic [7:0] OPC_SHR  = 8'h3D;
  localparam logic [7:0] OPC_AND  = 8'h75;
  localparam logic [7:0] OPC_OR   = 8'h76;
  localparam logic [7:0] OPC_XOR  = 8'h77;
  localparam logic [7:0] OPC_NOT  = 8'h78;
  localparam logic [7:0] OPC_NAND = 8'h79;
  localparam logic [7:0] OPC_NOR  = 8'h7A;
  localparam logic [7:0] OPC_XNOR = 8'h7B;
  localparam logic [7:0] OPC_JMP  = 8'h81;
  localparam logic [7:0] OPC_CALL = 8'h82;
  localparam logic [7:0] OPC_RET  = 8'h83;
  localparam logic [7:0] OPC_GOTO = 8'h84;
  localparam logic [7:0] OPC_JZ   = 8'h85;
  localparam logic [7:0] OPC_JNZ  = 8'h87;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_MOD  = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd8;
  localparam logic [3:0] ALU_NAND = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_XNOR = 4'd11;
  localparam logic [3:0] ALU_CMP  = 4'd12;
  localparam logic [3:0] ALU_SHL  = 4'd13;
  localparam logic [3:0] ALU_SHR  = 4'd14;
  localparam logic [3:0] ALU_NOT  = 4'd15;

  typedef enum logic [3:0] {
    ST_START, ST_FETCH, ST_DECODE, ST_EXEC, ST_WAIT_ALU, ST_WB,
    ST_BRANCH, ST_CALL, ST_RET, ST_HALT, ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LONG, CLS_BRANCH, CLS_CALL, CLS_RET, CLS_HALT, CLS_ILLEGAL
  } op_class_e;

  function automatic logic [3:0] alu_func(input logic [7:0] opc);
    case (opc)
      OPC_ADD:  return ALU_ADD;
      OPC_SUB:  return ALU_SUB;
      OPC_MUL:  return ALU_MUL;
      OPC_DIV:  return ALU_DIV;
      OPC_MOD:  return ALU_MOD;
      OPC_AND:  return ALU_AND;
      OPC_OR:   return ALU_OR;
      OPC_XOR:  return ALU_XOR;
      OPC_NAND: return ALU_NAND;
      OPC_NOR:  return ALU_NOR;
      OPC_XNOR: return ALU_XNOR;
      OPC_CMP:  return ALU_CMP;
      OPC_SHL:  return ALU_SHL;
      OPC_SHR:  return ALU_SHR;
      OPC_NOT:  return ALU_NOT;
      default:  return ALU_NONE;
    endcase
  endfunction

  function automatic op_class_e op_class(input logic [7:0] opc);
    case (opc)
      OPC_MUL, OPC_DIV, OPC_MOD:                  return CLS_LONG;
      OPC_JMP, OPC_GOTO, OPC_JZ, OPC_JNZ:         return CLS_BRANCH;
      OPC_CALL:                                   return CLS_CALL;
      OPC_RET:                                    return CLS_RET;
      OPC_HALT:                                   return CLS_HALT;
      default: return (alu_func(opc) != ALU_NONE) ? CLS_ALU : CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/uc_multicycle_if.sv
// uc_multicycle_if: bundle between the control unit and the datapath.
//   master - the control unit: takes ir/mem_ready/alu_done/zero_flag,
//            drives every load strobe, alu_op and the status flags.
//   slave  - the datapath side (IR, PC, register file, ALU, stack).
interface uc_multicycle_if #(
  parameter int OP_W     = 8,
  parameter int ALU_OP_W = 8
);
  logic [OP_W-1:0]     ir;
  logic                mem_ready;
  logic                alu_done;
  logic                zero_flag;
  logic                ir_load;
  logic                pc_inc;
  logic                pc_load;
  logic                reg_load_a;
  logic                reg_load_b;
  logic                reg_load_c;
  logic                alu_start;
  logic [ALU_OP_W-1:0] alu_op;
  logic                sp_push;
  logic                sp_pop;
  logic                trap;
  logic                halted;

  modport master (
    input  ir, mem_ready, alu_done, zero_flag,
    output ir_load, pc_inc, pc_load, reg_load_a, reg_load_b, reg_load_c,
           alu_start, alu_op, sp_push, sp_pop, trap, halted
  );

  modport slave (
    output ir, mem_ready, alu_done, zero_flag,
    input  ir_load, pc_inc, pc_load, reg_load_a, reg_load_b, reg_load_c,
           alu_start, alu_op, sp_push, sp_pop, trap, halted
  );
endinterface

// File: rtl/uc_multicycle_wait_counter.sv
// uc_wait_counter: loadable down-counter bounding the WAIT_ALU state.
//   clk_i, rst_ni : clock, synchronous active-low reset (count -> 0)
//   load_i        : load load_val_i (has priority over dec_i)
//   dec_i         : count down by one, saturating at zero
//   expired_o     : count is zero
module uc_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && !expired_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/uc_multicycle.sv
// uc_multicycle: handshaked multi-cycle control unit of the 8-bit CPU.
//   clk_i  : rising-edge clock
//   rst_ni : synchronous active-low reset
//   bus    : master side of uc_multicycle_if (instruction/ALU handshakes
//            in, datapath load strobes, alu_op, trap and halted out)
// Strobes are decoded from the registered state; only ir_load also looks
// at mem_ready so the IR captures in the cycle the fetch completes.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int OP_W        = 8,
  parameter int ALU_OP_W    = 8,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  uc_multicycle_if.master bus
);
  // The counter holds ALU_TIMEOUT-1 on WAIT entry, so the cycle where it
  // reads zero is the ALU_TIMEOUT-th WAIT cycle.
  localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                taken_q, taken_d;
  logic                long_q, long_d;
  logic                cmp_q, cmp_d;

  logic [7:0]  opc;
  logic        opc_hi_zero;
  op_class_e   cls;
  logic [3:0]  func;
  logic        br_taken;
  logic        cnt_load, cnt_dec, cnt_expired;

  logic ir_load, pc_inc, pc_load, reg_load_a, reg_load_b, reg_load_c;
  logic alu_start, sp_push, sp_pop, trap, halted;

  // Opcodes wider than 8 bits must have zero upper bits to be legal.
  assign opc         = bus.ir[7:0];
  assign opc_hi_zero = ((bus.ir >> 8) == '0);

  always_comb begin
    cls      = opc_hi_zero ? op_class(opc) : CLS_ILLEGAL;
    func     = opc_hi_zero ? alu_func(opc) : ALU_NONE;
    br_taken = 1'b1;
    if (opc == OPC_JZ)  br_taken = bus.zero_flag;
    if (opc == OPC_JNZ) br_taken = !bus.zero_flag;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_START;
      alu_op_q <= '0;
      taken_q  <= 1'b0;
      long_q   <= 1'b0;
      cmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      taken_q  <= taken_d;
      long_q   <= long_d;
      cmp_q    <= cmp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    taken_d    = taken_q;
    long_d     = long_q;
    cmp_d      = cmp_q;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_load_a = 1'b0;
    reg_load_b = 1'b0;
    reg_load_c = 1'b0;
    alu_start  = 1'b0;
    sp_push    = 1'b0;
    sp_pop     = 1'b0;
    trap       = 1'b0;
    halted     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        ir_load = bus.mem_ready;
        if (bus.mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_op_d = ALU_OP_W'(func);
        taken_d  = br_taken;
        long_d   = (cls == CLS_LONG);
        cmp_d    = (func == ALU_CMP);
        case (cls)
          CLS_ALU, CLS_LONG: state_d = ST_EXEC;
          CLS_BRANCH:        state_d = ST_BRANCH;
          CLS_CALL:          state_d = ST_CALL;
          CLS_RET:           state_d = ST_RET;
          CLS_HALT:          state_d = ST_HALT;
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        reg_load_a = 1'b1;
        reg_load_b = 1'b1;
        alu_start  = long_q;
        cnt_load   = long_q;
        state_d    = long_q ? ST_WAIT_ALU : ST_WB;
      end
      ST_WAIT_ALU: begin
        cnt_dec = 1'b1;
        // A result arriving on the last allowed cycle still completes.
        if (bus.alu_done)     state_d = ST_WB;
        else if (cnt_expired) state_d = ST_TRAP;
      end
      ST_WB: begin
        pc_inc     = 1'b1;
        reg_load_c = !cmp_q;  // CMP only updates flags
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        pc_load = taken_q;
        pc_inc  = !taken_q;
        state_d = ST_FETCH;
      end
      ST_CALL: begin
        sp_push = 1'b1;
        pc_load = 1'b1;
        state_d = ST_FETCH;
      end
      ST_RET: begin
        sp_pop  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      ST_TRAP: trap   = 1'b1;
      default: state_d = ST_TRAP;
    endcase
  end

  uc_wait_counter #(.W(CNT_W)) u_wait_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .expired_o  (cnt_expired)
  );

  // Outputs are forced low while reset is asserted, before the state
  // register has been cleared by the reset edge.
  assign bus.ir_load    = rst_ni & ir_load;
  assign bus.pc_inc     = rst_ni & pc_inc;
  assign bus.pc_load    = rst_ni & pc_load;
  assign bus.reg_load_a = rst_ni & reg_load_a;
  assign bus.reg_load_b = rst_ni & reg_load_b;
  assign bus.reg_load_c = rst_ni & reg_load_c;
  assign bus.alu_start  = rst_ni & alu_start;
  assign bus.sp_push    = rst_ni & sp_push;
  assign bus.sp_pop     = rst_ni & sp_pop;
  assign bus.trap       = rst_ni & trap;
  assign bus.halted     = rst_ni & halted;
  assign bus.alu_op     = rst_ni ? alu_op_q : '0;
endmodule

// File: tb/tb_uc_multicycle.sv
// Testbench for uc_multicycle: directed and random instructions, each
// expanded by a per-instruction timeline model into expected strobes.
module tb_uc_multicycle;
  localparam int T = 16;

  // Expected-strobe masks, bit order matches obs below.
  localparam logic [10:0] IRL = 11'b100_0000_0000;
  localparam logic [10:0] PCI = 11'b010_0000_0000;
  localparam logic [10:0] PCL = 11'b001_0000_0000;
  localparam logic [10:0] RA  = 11'b000_1000_0000;
  localparam logic [10:0] RB  = 11'b000_0100_0000;
  localparam logic [10:0] RC  = 11'b000_0010_0000;
  localparam logic [10:0] AS  = 11'b000_0001_0000;
  localparam logic [10:0] PU  = 11'b000_0000_1000;
  localparam logic [10:0] PO  = 11'b000_0000_0100;
  localparam logic [10:0] TR  = 11'b000_0000_0010;
  localparam logic [10:0] HA  = 11'b000_0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] cur_op = 8'h00;

  always #5 clk = ~clk;

  uc_multicycle_if #(.OP_W(8), .ALU_OP_W(8)) ifc ();

  uc_multicycle #(.OP_W(8), .ALU_OP_W(8), .ALU_TIMEOUT(T)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc)
  );

  logic [10:0] obs;
  assign obs = {ifc.ir_load, ifc.pc_inc, ifc.pc_load, ifc.reg_load_a,
                ifc.reg_load_b, ifc.reg_load_c, ifc.alu_start, ifc.sp_push,
                ifc.sp_pop, ifc.trap, ifc.halted};

  logic [7:0] legal_ops [21] = '{8'h01, 8'h02, 8'h75, 8'h76, 8'h77, 8'h78,
    8'h79, 8'h7A, 8'h7B, 8'h3C, 8'h3D, 8'h1F, 8'h03, 8'h04, 8'h05, 8'h81,
    8'h84, 8'h85, 8'h87, 8'h82, 8'h83};

  // 0 short ALU, 1 long ALU, 2 JMP/GOTO, 3 JZ, 4 JNZ, 5 CALL, 6 RET,
  // 7 HALT, 8 illegal
  function automatic int kind(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A, 8'h7B,
      8'h3C, 8'h3D, 8'h1F: return 0;
      8'h03, 8'h04, 8'h05: return 1;
      8'h81, 8'h84:        return 2;
      8'h85:               return 3;
      8'h87:               return 4;
      8'h82:               return 5;
      8'h83:               return 6;
      8'hFF:               return 7;
      default:             return 8;
    endcase
  endfunction

  function automatic logic [7:0] func_code(input logic [7:0] op);
    case (op)
      8'h01: return 8'd1;  8'h02: return 8'd2;  8'h03: return 8'd3;
      8'h04: return 8'd4;  8'h05: return 8'd5;  8'h75: return 8'd6;
      8'h76: return 8'd7;  8'h77: return 8'd8;  8'h79: return 8'd9;
      8'h7A: return 8'd10; 8'h7B: return 8'd11; 8'h1F: return 8'd12;
      8'h3C: return 8'd13; 8'h3D: return 8'd14; 8'h78: return 8'd15;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, advance.
  task automatic cyc(input logic mr, input logic ad, input logic z,
                     input logic [10:0] exp, input bit chk_op,
                     input logic [7:0] exp_op, input string tag);
    ifc.mem_ready = mr;
    ifc.alu_done  = ad;
    ifc.zero_flag = z;
    @(negedge clk);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s op=%h: strobes got %b want %b", tag, cur_op, obs, exp);
    end
    if (chk_op) begin
      checks++;
      assert (ifc.alu_op === exp_op) else begin
        errors++;
        $error("FAIL %s_aluop op=%h: got %0d want %0d", tag, cur_op,
               ifc.alu_op, exp_op);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Two cycles in reset, then one cycle in START after release.
  task automatic do_reset(input logic ad);
    rst_n = 1'b0;
    cyc(rb(), ad, rb(), '0, 1'b1, 8'd0, "in_reset");
    cyc(rb(), ad, rb(), '0, 1'b1, 8'd0, "in_reset");
    rst_n = 1'b1;
    cyc(rb(), ad, rb(), '0, 1'b1, 8'd0, "after_reset");
  endtask

  // Run one instruction from FETCH. ndone: WAIT cycle on which alu_done
  // pulses (outside 1..T means never). abort_at>0 returns while the DUT
  // is sitting in that WAIT cycle.
  task automatic run_instr(input logic [7:0] op, input logic zf,
                           input int mdly, input int ndone,
                           input int abort_at);
    int k;
    logic [7:0] f;
    logic d;
    k = kind(op);
    f = func_code(op);
    cur_op = op;
    ifc.ir = op;
    for (int i = 0; i < mdly; i++) cyc(1'b0, rb(), rb(), '0, 1'b0, 8'd0, "fetch_wait");
    cyc(1'b1, rb(), rb(), IRL, 1'b0, 8'd0, "fetch");
    cyc(rb(), rb(), zf, '0, 1'b0, 8'd0, "decode");
    case (k)
      0: begin
        cyc(rb(), rb(), rb(), RA | RB, 1'b1, f, "exec");
        cyc(rb(), rb(), rb(), PCI | ((op == 8'h1F) ? 11'd0 : RC), 1'b1, f, "wb");
      end
      1: begin
        cyc(rb(), rb(), rb(), RA | RB | AS, 1'b1, f, "exec_long");
        for (int w = 1; w <= T; w++) begin
          if (abort_at == w) return;
          d = (ndone == w);
          cyc(rb(), d, rb(), '0, 1'b1, f, "wait_alu");
          if (d) break;
        end
        if (ndone >= 1 && ndone <= T)
          cyc(rb(), rb(), rb(), PCI | RC, 1'b1, f, "wb_long");
        else
          for (int i = 0; i < 10; i++) cyc(rb(), rb(), rb(), TR, 1'b0, 8'd0, "timeout_trap");
      end
      2: cyc(rb(), rb(), rb(), PCL, 1'b1, 8'd0, "jmp");
      3: cyc(rb(), rb(), rb(), zf ? PCL : PCI, 1'b1, 8'd0, "jz");
      4: cyc(rb(), rb(), rb(), zf ? PCI : PCL, 1'b1, 8'd0, "jnz");
      5: cyc(rb(), rb(), rb(), PU | PCL, 1'b1, 8'd0, "call");
      6: cyc(rb(), rb(), rb(), PO, 1'b1, 8'd0, "ret");
      7: for (int i = 0; i < 10; i++) cyc(rb(), rb(), rb(), HA, 1'b1, 8'd0, "halt_hold");
      default: for (int i = 0; i < 10; i++) cyc(rb(), rb(), rb(), TR, 1'b1, 8'd0, "illegal_trap");
    endcase
  endtask

  initial begin
    logic [7:0] op;
    ifc.ir = 8'h00;
    ifc.mem_ready = 1'b0;
    ifc.alu_done = 1'b0;
    ifc.zero_flag = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Directed instructions.
    run_instr(8'h01, 1'b0, 0, 0, 0);   // ADD
    run_instr(8'h03, 1'b0, 0, 5, 0);   // MUL, done after 5 WAIT cycles
    run_instr(8'h85, 1'b1, 0, 0, 0);   // JZ taken
    run_instr(8'h85, 1'b0, 0, 0, 0);   // JZ not taken
    run_instr(8'h87, 1'b1, 0, 0, 0);   // JNZ not taken
    run_instr(8'h87, 1'b0, 0, 0, 0);   // JNZ taken
    run_instr(8'h82, 1'b0, 0, 0, 0);   // CALL
    run_instr(8'h83, 1'b0, 0, 0, 0);   // RET
    run_instr(8'h1F, 1'b0, 0, 0, 0);   // CMP: no reg_load_c
    run_instr(8'h01, 1'b0, 3, 0, 0);   // mem_ready low for 3 cycles
    run_instr(8'h05, 1'b0, 0, T, 0);   // done on the timeout cycle wins
    run_instr(8'h04, 1'b0, 0, 1, 0);   // done on first WAIT cycle
    run_instr(8'h04, 1'b0, 0, 0, 0);   // DIV, no done -> trap
    do_reset(1'b0);
    run_instr(8'h00, 1'b0, 0, 0, 0);   // illegal -> trap
    do_reset(1'b0);
    run_instr(8'hFF, 1'b0, 0, 0, 0);   // HALT
    do_reset(1'b0);

    // Reset in the middle of WAIT_ALU with a late alu_done.
    run_instr(8'h04, 1'b0, 0, 0, 3);
    do_reset(1'b1);
    run_instr(8'h02, 1'b0, 0, 0, 0);

    // Random legal instruction stream.
    for (int n = 0; n < 60; n++) begin
      op = legal_ops[$urandom_range(0, 20)];
      run_instr(op, rb(), $urandom_range(0, 2), $urandom_range(1, T), 0);
    end

    // Random illegal opcodes.
    for (int n = 0; n < 4; n++) begin
      op = 8'($urandom_range(0, 255));
      while (kind(op) != 8) op = 8'($urandom_range(0, 255));
      run_instr(op, rb(), 0, 0, 0);
      do_reset(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
